amp_i2c_cfg_master: RTL and testbench
=====================================

// Module: amp_i2c_cfg_master
// PURPOSE
//   Parametrised I2C write-only configuration master for the amp frontend. On a send_cfg rising
//   edge it walks an external table of N_REGS {reg,data} entries and issues one I2C register
//   write per entry to a fixed device address. Per-entry ACK checking with bounded retry,
//   busy/done/error status. Sits between the system config logic and the amplifier I2C pins.
// PARAMETERS
//   DEV_ADDR  7'h4D  7-bit slave address; address byte on the wire = {DEV_ADDR,1'b0}
//   N_REGS    8      number of table entries sent per run (1..256)
//   QTR_DIV   250    clk cycles per quarter SCL period (250 @100 MHz -> 100 kHz SCL); >=2
//   RETRIES   2      extra attempts per entry after a NACK (0..7)
//   IDX_W     $clog2(N_REGS) (min 1)  width of cfg_idx
// PORTS
//   clk       in    1      system clock
//   reset     in    1      synchronous, active-high
//   send_cfg  in    1      level; rising edge starts a run
//   cfg_idx   out   IDX_W  table index of the current entry
//   cfg_word  in    16     table entry {reg[15:8],data[7:0]}; valid combinationally for cfg_idx
//   busy      out   1      high from accepted start until run end
//   done      out   1      one-cycle pulse at run end (success or abort)
//   ack_err   out   1      sticky: last run aborted on NACK; cleared at next accepted start
//   i2c_scl   out   1      open-drain style: driven 0 or 1'bz (external pull-up)
//   i2c_sda   inout 1      open-drain: driven 0 or 1'bz; read back for ACK
// BEHAVIOUR
//   Reset: scl/sda = z, busy=0, done=0, ack_err=0, cfg_idx=0, state IDLE, send_cfg edge reg=1
//   (so a level already high at reset release does not start a run). Reset mid-transfer
//   releases both lines on the next clk edge; no STOP generated.
//   Start: send_cfg 0->1 seen while IDLE -> busy=1 next cycle, cfg_idx=0, ack_err=0.
//   Edges while busy are ignored (not queued).
//   Timebase: quarter tick every QTR_DIV clks, counter restarted on leaving IDLE.
//   All bus changes occur only on ticks.
//   Bit slot = 4 quarters: Q0 SCL low, set SDA; Q1 SCL release; Q2 SCL high, sample SDA;
//   Q3 SCL low. No clock-stretching support (SCL readback not used).
//   FSM: IDLE -> START -> ADDR -> REG -> DATA -> STOP -> GAP -> (START | IDLE).
//     START: SDA low while SCL high (1 quarter), then SCL low (1 quarter).
//       cfg_word latched here.
//     ADDR/REG/DATA: 8 bits MSB first, then 9th slot with SDA released; SDA=1 at Q2 = NACK.
//     NACK at any byte -> STOP immediately; attempt counter++ ; if <= RETRIES retry same
//       entry, else set ack_err, abort run.
//     STOP: SDA low, SCL release, then SDA release (1 quarter each).
//     GAP: 4 quarters bus free, both lines z. Then next entry (cfg_idx++, attempt=0) or end.
//   End: after GAP of last entry (or abort STOP+GAP): busy=0 and done=1 same cycle; IDLE.
//   Wire bytes: {DEV_ADDR,0}, cfg_word[15:8], cfg_word[7:0]. cfg_idx wraps never;
//   run ends at N_REGS-1.
//   Entry duration without retry = 2+27*4+3+4 quarters. N_REGS=1 is legal.
// STRUCTURE
//   Package amp_i2c_pkg: state enum, quarter-phase enum, byte-select constants.
//   Sub-module amp_i2c_bit_phy: quarter-tick divider + single bit/START/STOP sequencer with
//   req/ack handshake and sampled SDA; top holds table walk, byte shift, retry and status.
// TESTING (tb uses QTR_DIV=4, N_REGS=2, RETRIES=2, table {16'h0110,16'h02A5}, slave model)
//   1 Reset held 10 cycles -> scl=z, sda=z, busy=0, done=0, ack_err=0, cfg_idx=0.
//   2 send_cfg 0->1, slave ACKs all -> bytes 9A 01 10, STOP, 9A 02 A5, STOP; one done pulse;
//     busy 0 same cycle; ack_err=0.
//   3 Slave NACKs data byte of entry 1 once -> STOP, entry 1 resent in full, then entry 2;
//     ack_err=0.
//   4 Slave NACKs address always -> exactly 3 address attempts, each followed by STOP;
//     ack_err=1; done pulse; entry 2 never sent.
//   5 send_cfg toggled during run -> no restart/extra traffic; new 0->1 after done ->
//     second full run, ack_err cleared at start.
//   6 reset asserted in middle of REG byte with SCL low -> next cycle scl=z, sda=z, busy=0;
//     later send_cfg edge runs cleanly.

Source files
------------

// File: rtl/amp_i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : amp_i2c_pkg
// Description : Shared types and constants for the amp I2C config master.
// Revision    : 1.0 - initial release
// ============================================================================
package amp_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_REG   = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5,
        ST_GAP   = 3'd6
    } cfg_state_t;

    typedef enum logic [1:0] {
        QP_0 = 2'd0,
        QP_1 = 2'd1,
        QP_2 = 2'd2,
        QP_3 = 2'd3
    } qphase_t;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_BIT   = 2'd1,
        OP_STOP  = 2'd2,
        OP_GAP   = 2'd3
    } phy_op_t;

    localparam logic [1:0] c_sel_addr = 2'd0;
    localparam logic [1:0] c_sel_reg  = 2'd1;
    localparam logic [1:0] c_sel_data = 2'd2;

    function automatic logic [7:0] wire_byte(input logic [1:0]  sel,
                                             input logic [6:0]  dev,
                                             input logic [15:0] word);
        logic [7:0] b;
        case (sel)
            c_sel_addr: b = {dev, 1'b0};
            c_sel_reg:  b = word[15:8];
            default:    b = word[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/amp_i2c_bit_phy.sv
`default_nettype none
// ============================================================================
// Module      : amp_i2c_bit_phy
// Description : Quarter-tick timebase plus single START/bit/STOP/gap sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module amp_i2c_bit_phy
    import amp_i2c_pkg::*;
#(
    parameter int QTR_DIV = 250
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    run,
    input  logic    req,
    input  phy_op_t op,
    input  logic    tx_bit,
    input  logic    sda_in,
    output logic    ack,
    output logic    rx_bit,
    output logic    scl_low,
    output logic    sda_low
);

    localparam int                 c_cnt_w   = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(QTR_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_tick;
    logic               w_last;
    logic               r_active;
    phy_op_t            r_op;
    logic               r_bit;
    qphase_t            r_q;
    logic               r_scl_low;
    logic               r_sda_low;
    logic               r_rx;

    assign w_tick = (r_cnt == c_cnt_max);

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_last = 1'b0;
        case (r_op)
            OP_START: w_last = (r_q == QP_1);
            OP_STOP:  w_last = (r_q == QP_2);
            default:  w_last = (r_q == QP_3);
        endcase
    end

    // Ack coincides with the final quarter so the caller can present the
    // next op well before the following tick.
    assign ack = w_tick && r_active && w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active  <= 1'b0;
            r_op      <= OP_GAP;
            r_bit     <= 1'b1;
            r_q       <= QP_0;
            r_scl_low <= 1'b0;
            r_sda_low <= 1'b0;
            r_rx      <= 1'b1;
        end else if (!r_active) begin
            if (req) begin
                r_active <= 1'b1;
                r_op     <= op;
                r_bit    <= tx_bit;
                r_q      <= QP_0;
            end
        end else if (w_tick) begin
            r_q <= qphase_t'(r_q + 2'd1);
            if (w_last) begin
                r_active <= 1'b0;
            end
            case (r_op)
                OP_START: begin
                    if (r_q == QP_0) r_sda_low <= 1'b1;
                    else             r_scl_low <= 1'b1;
                end
                OP_BIT: begin
                    case (r_q)
                        QP_0: begin
                            r_scl_low <= 1'b1;
                            r_sda_low <= ~r_bit;
                        end
                        QP_1:    r_scl_low <= 1'b0;
                        QP_2:    r_rx      <= sda_in;
                        default: r_scl_low <= 1'b1;
                    endcase
                end
                OP_STOP: begin
                    case (r_q)
                        QP_0:    r_sda_low <= 1'b1;
                        QP_1:    r_scl_low <= 1'b0;
                        default: r_sda_low <= 1'b0;
                    endcase
                end
                default: begin
                    r_scl_low <= 1'b0;
                    r_sda_low <= 1'b0;
                end
            endcase
        end
    end

    assign rx_bit  = r_rx;
    assign scl_low = r_scl_low;
    assign sda_low = r_sda_low;

endmodule
`default_nettype wire

// File: rtl/amp_i2c_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : amp_i2c_cfg_master
// Description : Walks a register table and writes each entry over I2C.
// Revision    : 1.0 - initial release
// ============================================================================
module amp_i2c_cfg_master
    import amp_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h4D,
    parameter int         N_REGS   = 8,
    parameter int         QTR_DIV  = 250,
    parameter int         RETRIES  = 2,
    parameter int         IDX_W    = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             send_cfg,
    output logic [IDX_W-1:0] cfg_idx,
    input  logic [15:0]      cfg_word,
    output logic             busy,
    output logic             done,
    output logic             ack_err,
    output wire              i2c_scl,
    inout  wire              i2c_sda
);

    cfg_state_t       r_state;
    cfg_state_t       w_state_next;
    logic             r_busy;
    logic             r_done;
    logic             r_ack_err;
    logic             r_send_q;
    logic             r_nack;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_bitcnt;
    logic [7:0]       r_shift;
    logic [15:0]      r_word;
    logic [2:0]       r_attempt;

    logic             w_start;
    logic             w_finish;
    logic             w_phy_req;
    phy_op_t          w_op;
    logic             w_tx_bit;
    logic             w_phy_ack;
    logic             w_rx_bit;
    logic             w_scl_low;
    logic             w_sda_low;

    assign w_start  = (r_state == ST_IDLE) && send_cfg && !r_send_q;
    // After the gap: give up once retries are spent, else stop after the last entry.
    assign w_finish = r_nack ? (r_attempt >= 3'(RETRIES))
                             : (r_idx == IDX_W'(N_REGS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_phy_req    = 1'b0;
        w_op         = OP_GAP;
        w_tx_bit     = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_next = ST_START;
            end
            ST_START: begin
                w_phy_req = 1'b1;
                w_op      = OP_START;
                if (w_phy_ack) w_state_next = ST_ADDR;
            end
            ST_ADDR, ST_REG, ST_DATA: begin
                w_phy_req = 1'b1;
                w_op      = OP_BIT;
                w_tx_bit  = (r_bitcnt == 4'd8) ? 1'b1 : r_shift[7];
                if (w_phy_ack && (r_bitcnt == 4'd8)) begin
                    if (w_rx_bit)                w_state_next = ST_STOP;
                    else if (r_state == ST_ADDR) w_state_next = ST_REG;
                    else if (r_state == ST_REG)  w_state_next = ST_DATA;
                    else                         w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                w_phy_req = 1'b1;
                w_op      = OP_STOP;
                if (w_phy_ack) w_state_next = ST_GAP;
            end
            ST_GAP: begin
                w_phy_req = 1'b1;
                w_op      = OP_GAP;
                if (w_phy_ack) w_state_next = w_finish ? ST_IDLE : ST_START;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_send_q  <= 1'b1;
            r_nack    <= 1'b0;
            r_idx     <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_word    <= '0;
            r_attempt <= '0;
        end else begin
            r_send_q <= send_cfg;
            r_done   <= 1'b0;
            if (w_start) begin
                r_busy    <= 1'b1;
                r_idx     <= '0;
                r_ack_err <= 1'b0;
                r_attempt <= '0;
                r_nack    <= 1'b0;
            end
            if (w_phy_ack) begin
                case (r_state)
                    ST_START: begin
                        r_word   <= cfg_word;
                        r_shift  <= wire_byte(c_sel_addr, DEV_ADDR, cfg_word);
                        r_bitcnt <= '0;
                        r_nack   <= 1'b0;
                    end
                    ST_ADDR, ST_REG, ST_DATA: begin
                        if (r_bitcnt == 4'd8) begin
                            r_bitcnt <= '0;
                            r_nack   <= w_rx_bit;
                            r_shift  <= wire_byte((r_state == ST_ADDR) ? c_sel_reg : c_sel_data,
                                                  DEV_ADDR, r_word);
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                            r_shift  <= {r_shift[6:0], 1'b0};
                        end
                    end
                    ST_GAP: begin
                        if (r_nack) begin
                            if (w_finish) r_ack_err <= 1'b1;
                            else          r_attempt <= r_attempt + 3'd1;
                        end else if (!w_finish) begin
                            r_idx     <= r_idx + 1'b1;
                            r_attempt <= '0;
                        end
                        if (w_finish) begin
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    amp_i2c_bit_phy #(
        .QTR_DIV (QTR_DIV)
    ) u_phy (
        .clk     (clk),
        .reset   (reset),
        .run     (r_busy),
        .req     (w_phy_req),
        .op      (w_op),
        .tx_bit  (w_tx_bit),
        .sda_in  (i2c_sda),
        .ack     (w_phy_ack),
        .rx_bit  (w_rx_bit),
        .scl_low (w_scl_low),
        .sda_low (w_sda_low)
    );

    assign i2c_scl = w_scl_low ? 1'b0 : 1'bz;
    assign i2c_sda = w_sda_low ? 1'b0 : 1'bz;

    assign cfg_idx = r_idx;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ack_err = r_ack_err;

endmodule
`default_nettype wire

// File: tb/tb_amp_i2c_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_amp_i2c_cfg_master
// Description : I2C bus monitor/slave plus transaction-level model for the master.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_amp_i2c_cfg_master;

    localparam int c_qtr      = 4;
    localparam int c_nregs    = 2;
    localparam int c_retries  = 2;
    localparam int c_mk_start = 'h200;
    localparam int c_mk_stop  = 'h100;
    localparam logic [7:0] c_addr_byte = 8'h9A;

    logic        clk = 1'b0;
    logic        reset;
    logic        send_cfg;
    logic [0:0]  cfg_idx;
    logic [15:0] cfg_word;
    logic        busy;
    logic        done;
    logic        ack_err;
    wire         scl;
    wire         sda;
    logic        slave_low = 1'b0;
    logic [15:0] tbl [c_nregs];

    pullup (scl);
    pullup (sda);
    assign sda      = slave_low ? 1'b0 : 1'bz;
    assign cfg_word = tbl[cfg_idx];

    always #5 clk = ~clk;

    amp_i2c_cfg_master #(
        .DEV_ADDR (7'h4D),
        .N_REGS   (c_nregs),
        .QTR_DIV  (c_qtr),
        .RETRIES  (c_retries)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .send_cfg (send_cfg),
        .cfg_idx  (cfg_idx),
        .cfg_word (cfg_word),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .i2c_scl  (scl),
        .i2c_sda  (sda)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Slave NACK decisions, consumed one per byte in wire order.
    bit nack_plan [64];

    // Bus monitor and ACKing slave.
    int         obs_q[$];
    logic       mon_clear = 1'b1;
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    int         bitn = 0;
    int         byte_i = 0;
    int         plan_k = 0;
    logic [7:0] sh = 8'h00;

    always @(negedge clk) begin
        if (mon_clear) begin
            bitn      <= 0;
            byte_i    <= 0;
            plan_k    <= 0;
            slave_low <= 1'b0;
            p_scl     <= 1'b1;
            p_sda     <= 1'b1;
            obs_q.delete();
        end else begin
            p_scl <= scl;
            p_sda <= sda;
            if (p_scl && scl && p_sda && !sda) begin
                obs_q.push_back(c_mk_start);
                bitn   <= 0;
                byte_i <= 0;
            end else if (p_scl && scl && !p_sda && sda) begin
                obs_q.push_back(c_mk_stop);
                bitn      <= 0;
                slave_low <= 1'b0;
            end else if (!p_scl && scl) begin
                sh <= {sh[6:0], sda};
                if (bitn == 7) begin
                    obs_q.push_back(int'({sh[6:0], sda}));
                    byte_i <= byte_i + 1;
                end
                bitn <= bitn + 1;
            end else if (p_scl && !scl) begin
                if (bitn == 8) begin
                    slave_low <= !nack_plan[plan_k & 63];
                    plan_k    <= plan_k + 1;
                end else if (bitn == 9) begin
                    slave_low <= 1'b0;
                    bitn      <= 0;
                end
            end
        end
    end

    // Transaction-level reference: frames of START, bytes up to the first NACK, STOP.
    int exp_q[$];
    int exp_quarters;
    bit exp_err;

    task automatic model_run();
        int k;
        k = 0;
        exp_q.delete();
        exp_quarters = 0;
        exp_err = 1'b0;
        for (int e = 0; e < c_nregs && !exp_err; e++) begin
            int attempt;
            bit ok;
            attempt = 0;
            ok = 1'b0;
            while (!ok && !exp_err) begin
                logic [7:0] wb [3];
                int nb;
                bit nacked;
                wb[0] = c_addr_byte;
                wb[1] = tbl[e][15:8];
                wb[2] = tbl[e][7:0];
                nb = 0;
                nacked = 1'b0;
                exp_q.push_back(c_mk_start);
                for (int b = 0; b < 3 && !nacked; b++) begin
                    exp_q.push_back(int'(wb[b]));
                    nb++;
                    if (nack_plan[k]) nacked = 1'b1;
                    k++;
                end
                exp_q.push_back(c_mk_stop);
                exp_quarters += 2 + nb * 36 + 3 + 4;
                if (!nacked) ok = 1'b1;
                else begin
                    attempt++;
                    if (attempt > c_retries) exp_err = 1'b1;
                end
            end
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 64; i++) nack_plan[i] = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        mon_clear = 1'b1;
        @(posedge clk);
        mon_clear = 1'b0;
    endtask

    task automatic run_once(input string tag, input bit toggle_mid);
        int  busy_cyc;
        int  done_cnt;
        int  cyc;
        int  n;
        bit  finished;
        bit  seen_busy;
        busy_cyc  = 0;
        done_cnt  = 0;
        cyc       = 0;
        finished  = 1'b0;
        seen_busy = 1'b0;
        model_run();
        send_cfg = 1'b0;
        pulse_clear();
        @(negedge clk);
        @(negedge clk);
        send_cfg = 1'b1;
        while (!finished && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check_eq({tag, ".busy_next_cycle"}, busy, 1'b1);
            if (busy) begin
                if (!seen_busy) check_eq({tag, ".ack_err_cleared"}, ack_err, 1'b0);
                seen_busy = 1'b1;
                busy_cyc++;
            end
            if (toggle_mid && cyc == 300) send_cfg = 1'b0;
            if (toggle_mid && cyc == 310) send_cfg = 1'b1;
            if (done) begin
                done_cnt++;
                check_eq({tag, ".busy_low_at_done"}, busy, 1'b0);
                finished = 1'b1;
            end
        end
        check_eq({tag, ".run_finished"}, finished, 1'b1);
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_cyc++;
        end
        check_eq({tag, ".done_pulses"}, done_cnt, 1);
        check_eq({tag, ".busy_cycles"}, busy_cyc, exp_quarters * c_qtr);
        check_eq({tag, ".ack_err"}, ack_err, exp_err);
        check_eq({tag, ".bus_items"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s.item%0d", tag, i),
                     (i < obs_q.size()) ? obs_q[i] : -1,
                     (i < exp_q.size()) ? exp_q[i] : -1);
        end
    endtask

    initial begin
        bit found;
        reset    = 1'b1;
        send_cfg = 1'b0;
        tbl[0]   = 16'h0110;
        tbl[1]   = 16'h02A5;
        clear_plan();
        repeat (10) @(negedge clk);
        check_eq("rst.scl", scl, 1'b1);
        check_eq("rst.sda", sda, 1'b1);
        check_eq("rst.busy", busy, 1'b0);
        check_eq("rst.done", done, 1'b0);
        check_eq("rst.ack_err", ack_err, 1'b0);
        check_eq("rst.cfg_idx", cfg_idx, 1'b0);
        reset = 1'b0;

        run_once("all_ack", 1'b0);

        clear_plan();
        nack_plan[2] = 1'b1;
        run_once("data_nack_once", 1'b0);

        clear_plan();
        for (int i = 0; i < 3; i++) nack_plan[i] = 1'b1;
        run_once("addr_nack_always", 1'b0);

        clear_plan();
        run_once("toggle_mid_run", 1'b1);
        run_once("second_run", 1'b0);

        // Reset in the middle of the register byte while SCL is low.
        clear_plan();
        send_cfg = 1'b0;
        pulse_clear();
        @(negedge clk);
        send_cfg = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            @(negedge clk);
            #1;
            if (byte_i == 1 && bitn == 3 && !scl) found = 1'b1;
        end
        check_eq("midreset.reached_reg_byte", found, 1'b1);
        @(negedge clk);
        reset     = 1'b1;
        mon_clear = 1'b1;
        @(negedge clk);
        check_eq("midreset.scl", scl, 1'b1);
        check_eq("midreset.sda", sda, 1'b1);
        check_eq("midreset.busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("midreset.no_start_on_level", busy, 1'b0);
        check_eq("midreset.bus_idle", {scl, sda}, 2'b11);
        run_once("after_reset", 1'b0);

        for (int r = 0; r < 3; r++) begin
            tbl[0] = 16'($urandom);
            tbl[1] = 16'($urandom);
            for (int i = 0; i < 64; i++) nack_plan[i] = ($urandom_range(0, 4) == 0);
            run_once($sformatf("rand%0d", r), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
